// File: rtl/win_gen_kxk.sv
// KxK sliding-window generator: buffers one bit-plane frame, then streams zero-padded
// windows one bit-plane per beat in raster or column-pair snake order.
module win_gen_kxk #(
  parameter int unsigned DW      = 128,
  parameter int unsigned NB      = 8,
  parameter int unsigned K       = 3,
  parameter int unsigned MAX_PIC = 16,
  parameter int unsigned PW      = 8,
  localparam int unsigned BW     = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                START,
  input  logic [PW-1:0]       PIC_SIZE,
  input  logic [1:0]          PADDING,
  input  logic                STRIDE,
  input  logic                MODE,
  input  logic [DW-1:0]       DATA,
  input  logic                DATA_VLD,
  output logic                DATA_RDY,
  input  logic                DATA_SOP,
  input  logic                DATA_HSYNC,
  output logic [K*K*DW-1:0]   OPU,
  output logic                OPU_VLD,
  input  logic                OPU_RDY,
  output logic [BW-1:0]       OPU_BIT,
  output logic [PW-1:0]       OPU_X,
  output logic [PW-1:0]       OPU_Y,
  output logic                OPU_EOF,
  output logic                BUSY,
  output logic                ERR
);

  localparam int unsigned NPIX = MAX_PIC * MAX_PIC;
  localparam int unsigned AW   = $clog2(NPIX * NB);
  localparam int          KK   = int'(K * K);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pic_q, pic_d, wout_q, wout_d;
  logic [1:0]          pad_q, pad_d;
  logic                stride_q, stride_d, mode_q, mode_d, err_q, err_d;
  logic [PW-1:0]       wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [BW-1:0]       wr_pl_q, wr_pl_d;
  logic [PW-1:0]       g_i_q, g_i_d, g_p_q, g_p_d;
  logic                g_s_q, g_s_d, g_done_q, g_done_d;
  logic [BW-1:0]       g_bit_q, g_bit_d;
  logic [K*K*DW-1:0]   opu_q, opu_d;
  logic                opu_vld_q, opu_vld_d, opu_eof_q, opu_eof_d;
  logic [BW-1:0]       opu_bit_q, opu_bit_d;
  logic [PW-1:0]       opu_x_q, opu_x_d, opu_y_q, opu_y_d;

  logic [DW-1:0]       mem_q [NPIX*NB];

  logic                cfg_bad;
  logic [PW-1:0]       cfg_wout;
  logic [PW-1:0]       eff_row, eff_col;
  logic [BW-1:0]       eff_pl;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [K*K*DW-1:0]   win_data;
  logic [PW-1:0]       win_x, win_y;
  logic                win_last, win_single;

  // Configuration check and output-grid size
  always_comb begin
    int pic, pad, span;
    pic      = int'(PIC_SIZE);
    pad      = int'(PADDING);
    span     = pic + 2 * pad;
    cfg_bad  = (pic == 0) || (pic > int'(MAX_PIC)) || (pad > (int'(K) - 1) / 2) ||
               (span < int'(K));
    cfg_wout = '0;
    if (!cfg_bad) cfg_wout = PW'((span - int'(K)) / (STRIDE ? 2 : 1) + 1);
  end

  // A SOP in the same cycle as a beat lands that beat on pixel 0 plane 0
  always_comb begin
    eff_row = DATA_SOP ? '0 : wr_row_q;
    eff_col = DATA_SOP ? '0 : wr_col_q;
    eff_pl  = DATA_SOP ? '0 : wr_pl_q;
    wr_en   = (state_q == StLoad) && DATA_VLD;
    wr_addr = AW'((int'(eff_row) * int'(MAX_PIC) + int'(eff_col)) * int'(NB) + int'(eff_pl));
  end

  always_ff @(posedge SYS_CLK) begin
    if (wr_en) mem_q[wr_addr] <= DATA;
  end

  // Current window position and its gathered bit-plane
  always_comb begin
    int s_w, wo, ii, pp, col, x0, y0, py, px, pic;
    logic [DW-1:0] elem;
    s_w  = stride_q ? 2 : 1;
    wo   = int'(wout_q);
    ii   = int'(g_i_q);
    pp   = int'(g_p_q);
    pic  = int'(pic_q);
    win_single = mode_q && (2 * pp + 1 >= wo);
    if (!mode_q)         col = pp;
    else if (win_single) col = 2 * pp;
    else if (ii % 2 == 1) col = 2 * pp + (g_s_q ? 0 : 1);
    else                 col = 2 * pp + (g_s_q ? 1 : 0);
    x0    = col * s_w - int'(pad_q);
    y0    = ii * s_w - int'(pad_q);
    win_x = PW'(x0);
    win_y = PW'(y0);
    if (mode_q) win_last = (ii == wo - 1) && (2 * pp + 2 >= wo) && (win_single || g_s_q);
    else        win_last = (ii == wo - 1) && (pp == wo - 1);
    win_data = '0;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        py   = y0 + r;
        px   = x0 + c;
        elem = '0;
        if (py >= 0 && py < pic && px >= 0 && px < pic) begin
          elem = mem_q[AW'((py * int'(MAX_PIC) + px) * int'(NB) + int'(g_bit_q))];
        end
        win_data[(KK - 1 - (r * int'(K) + c)) * int'(DW) +: DW] = elem;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pic_d     = pic_q;
    wout_d    = wout_q;
    pad_d     = pad_q;
    stride_d  = stride_q;
    mode_d    = mode_q;
    err_d     = err_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_pl_d   = wr_pl_q;
    g_i_d     = g_i_q;
    g_p_d     = g_p_q;
    g_s_d     = g_s_q;
    g_bit_d   = g_bit_q;
    g_done_d  = g_done_q;
    opu_d     = opu_q;
    opu_vld_d = opu_vld_q;
    opu_eof_d = opu_eof_q;
    opu_bit_d = opu_bit_q;
    opu_x_d   = opu_x_q;
    opu_y_d   = opu_y_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          err_d = cfg_bad;
          if (!cfg_bad) begin
            pic_d    = PIC_SIZE;
            pad_d    = PADDING;
            stride_d = STRIDE;
            mode_d   = MODE;
            wout_d   = cfg_wout;
            wr_row_d = '0;
            wr_col_d = '0;
            wr_pl_d  = '0;
            g_i_d    = '0;
            g_p_d    = '0;
            g_s_d    = 1'b0;
            g_bit_d  = '0;
            g_done_d = 1'b0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        wr_row_d = eff_row;
        wr_col_d = eff_col;
        wr_pl_d  = eff_pl;
        if (DATA_VLD) begin
          if (DATA_HSYNC && !(eff_col == pic_q - PW'(1) && eff_pl == BW'(NB - 1))) err_d = 1'b1;
          if (eff_pl == BW'(NB - 1)) begin
            wr_pl_d = '0;
            if (eff_col == pic_q - PW'(1)) begin
              wr_col_d = '0;
              wr_row_d = eff_row + PW'(1);
              if (eff_row == pic_q - PW'(1)) state_d = StEmit;
            end else begin
              wr_col_d = eff_col + PW'(1);
            end
          end else begin
            wr_pl_d = eff_pl + BW'(1);
          end
        end
      end
      StEmit: begin
        if (opu_vld_q && OPU_RDY) begin
          opu_vld_d = 1'b0;
          if (opu_eof_q) state_d = StIdle;
        end
        if (!g_done_q && (!opu_vld_q || OPU_RDY)) begin
          opu_vld_d = 1'b1;
          opu_d     = win_data;
          opu_bit_d = g_bit_q;
          opu_x_d   = win_x;
          opu_y_d   = win_y;
          opu_eof_d = win_last && (g_bit_q == BW'(NB - 1));
          if (g_bit_q == BW'(NB - 1)) begin
            g_bit_d = '0;
            if (win_last) begin
              g_done_d = 1'b1;
            end else if (!mode_q) begin
              if (g_p_q == wout_q - PW'(1)) begin
                g_p_d = '0;
                g_i_d = g_i_q + PW'(1);
              end else begin
                g_p_d = g_p_q + PW'(1);
              end
            end else if (win_single || g_s_q) begin
              g_s_d = 1'b0;
              if (g_i_q == wout_q - PW'(1)) begin
                g_i_d = '0;
                g_p_d = g_p_q + PW'(1);
              end else begin
                g_i_d = g_i_q + PW'(1);
              end
            end else begin
              g_s_d = 1'b1;
            end
          end else begin
            g_bit_d = g_bit_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q   <= StIdle;
      pic_q     <= '0;
      wout_q    <= '0;
      pad_q     <= '0;
      stride_q  <= 1'b0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_pl_q   <= '0;
      g_i_q     <= '0;
      g_p_q     <= '0;
      g_s_q     <= 1'b0;
      g_bit_q   <= '0;
      g_done_q  <= 1'b0;
      opu_q     <= '0;
      opu_vld_q <= 1'b0;
      opu_eof_q <= 1'b0;
      opu_bit_q <= '0;
      opu_x_q   <= '0;
      opu_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      pic_q     <= pic_d;
      wout_q    <= wout_d;
      pad_q     <= pad_d;
      stride_q  <= stride_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_pl_q   <= wr_pl_d;
      g_i_q     <= g_i_d;
      g_p_q     <= g_p_d;
      g_s_q     <= g_s_d;
      g_bit_q   <= g_bit_d;
      g_done_q  <= g_done_d;
      opu_q     <= opu_d;
      opu_vld_q <= opu_vld_d;
      opu_eof_q <= opu_eof_d;
      opu_bit_q <= opu_bit_d;
      opu_x_q   <= opu_x_d;
      opu_y_q   <= opu_y_d;
    end
  end

  assign DATA_RDY = (state_q == StLoad);
  assign BUSY     = (state_q != StIdle);
  assign ERR      = err_q;
  assign OPU      = opu_q;
  assign OPU_VLD  = opu_vld_q;
  assign OPU_BIT  = opu_bit_q;
  assign OPU_X    = opu_x_q;
  assign OPU_Y    = opu_y_q;
  assign OPU_EOF  = opu_eof_q;

endmodule

// File: tb/tb_win_gen_kxk.sv
// Scoreboard bench for win_gen_kxk: stimulus pushes expected beats, a monitor pops and compares.
module tb_win_gen_kxk;
  localparam int DW = 16, NB = 8, K = 3, MAX_PIC = 16, PW = 8, BW = 3;
  localparam int KK = K * K;

  typedef struct {
    logic [KK*DW-1:0] opu;
    logic [BW-1:0]    b;
    logic [PW-1:0]    x;
    logic [PW-1:0]    y;
    logic             eof;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stride = 1'b0, mode = 1'b0;
  logic [PW-1:0] pic_size = '0;
  logic [1:0] padding = '0;
  logic [DW-1:0] data = '0;
  logic data_vld = 1'b0, data_sop = 1'b0, data_hsync = 1'b0, opu_rdy = 1'b1;
  logic data_rdy, opu_vld, opu_eof, busy, err;
  logic [KK*DW-1:0] opu;
  logic [BW-1:0] opu_bit;
  logic [PW-1:0] opu_x, opu_y;

  exp_t exp_q[$];
  logic [DW-1:0] img [MAX_PIC][MAX_PIC][NB];
  int n_cmp = 0, n_err = 0, mon_cnt = 0;
  int mon_x[$], mon_y[$], mon_eof[$], mon_ctr[$];

  win_gen_kxk #(.DW(DW), .NB(NB), .K(K), .MAX_PIC(MAX_PIC), .PW(PW)) dut (
    .SYS_CLK(clk), .SYS_RST(rst_n), .START(start), .PIC_SIZE(pic_size), .PADDING(padding),
    .STRIDE(stride), .MODE(mode), .DATA(data), .DATA_VLD(data_vld), .DATA_RDY(data_rdy),
    .DATA_SOP(data_sop), .DATA_HSYNC(data_hsync), .OPU(opu), .OPU_VLD(opu_vld),
    .OPU_RDY(opu_rdy), .OPU_BIT(opu_bit), .OPU_X(opu_x), .OPU_Y(opu_y), .OPU_EOF(opu_eof),
    .BUSY(busy), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: compares accepted beats and checks output stability across stalls
  initial begin
    logic pv, pr;
    logic [KK*DW-1:0] po;
    logic [BW-1:0] pb;
    logic [PW-1:0] px, py;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    po = '0;
    pb = '0;
    px = '0;
    py = '0;
    forever begin
      @(negedge clk);
      if (rst_n && opu_vld) begin
        if (pv && !pr) begin
          n_cmp++;
          if (opu !== po || opu_bit !== pb || opu_x !== px || opu_y !== py) begin
            n_err++;
            $display("FAIL stall_hold: got bit=%0d x=%0d y=%0d, required bit=%0d x=%0d y=%0d",
                     opu_bit, $signed(opu_x), $signed(opu_y), pb, $signed(px), $signed(py));
          end
        end
        if (opu_rdy) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got beat bit=%0d x=%0d y=%0d, required no beat",
                     opu_bit, $signed(opu_x), $signed(opu_y));
          end else begin
            e = exp_q.pop_front();
            if (opu !== e.opu || opu_bit !== e.b || opu_x !== e.x || opu_y !== e.y ||
                opu_eof !== e.eof) begin
              n_err++;
              $display("FAIL beat%0d: got opu=%h bit=%0d x=%0d y=%0d eof=%0b, required opu=%h bit=%0d x=%0d y=%0d eof=%0b",
                       mon_cnt, opu, opu_bit, $signed(opu_x), $signed(opu_y), opu_eof,
                       e.opu, e.b, $signed(e.x), $signed(e.y), e.eof);
            end
          end
          mon_x.push_back(int'($signed(opu_x)));
          mon_y.push_back(int'($signed(opu_y)));
          mon_eof.push_back(int'(opu_eof));
          mon_ctr.push_back(int'(opu[4*DW +: DW]));
          mon_cnt++;
        end
      end
      pv = rst_n && opu_vld;
      pr = opu_rdy;
      po = opu;
      pb = opu_bit;
      px = opu_x;
      py = opu_y;
    end
  end

  task automatic push_exp(input int pic, input int pad, input int s, input int md);
    int wout;
    int wi[$], wj[$];
    exp_t e;
    wout = (pic + 2 * pad - K) / s + 1;
    if (md == 0) begin
      for (int i = 0; i < wout; i++)
        for (int j = 0; j < wout; j++) begin wi.push_back(i); wj.push_back(j); end
    end else begin
      for (int p = 0; 2 * p < wout; p++)
        for (int i = 0; i < wout; i++) begin
          if (2 * p + 1 >= wout) begin wi.push_back(i); wj.push_back(2 * p); end
          else if (i % 2 == 0) begin
            wi.push_back(i); wj.push_back(2 * p); wi.push_back(i); wj.push_back(2 * p + 1);
          end else begin
            wi.push_back(i); wj.push_back(2 * p + 1); wi.push_back(i); wj.push_back(2 * p);
          end
        end
    end
    for (int w = 0; w < wi.size(); w++) begin
      for (int b = 0; b < NB; b++) begin
        e.opu = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            int yy, xx;
            yy = wi[w] * s - pad + r;
            xx = wj[w] * s - pad + c;
            if (yy >= 0 && yy < pic && xx >= 0 && xx < pic)
              e.opu[(KK - 1 - (r * K + c)) * DW +: DW] = img[yy][xx][b];
          end
        e.b   = BW'(b);
        e.x   = PW'(wj[w] * s - pad);
        e.y   = PW'(wi[w] * s - pad);
        e.eof = (w == wi.size() - 1) && (b == NB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int pic, input int pad, input int s, input int md);
    pic_size = PW'(pic);
    padding  = 2'(pad);
    stride   = (s == 2);
    mode     = md[0];
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Loads a frame; garbage>0 sends junk beats first and then restarts with SOP
  task automatic run_frame(input int pic, input int pad, input int s, input int md,
                           input int seed, input int garbage, input int bad_hs);
    int idx;
    for (int y = 0; y < MAX_PIC; y++)
      for (int x = 0; x < MAX_PIC; x++)
        for (int b = 0; b < NB; b++)
          img[y][x][b] = DW'((((y + 8 * x + seed) & 255) << 4) | b);
    push_exp(pic, pad, s, md);
    do_start(pic, pad, s, md);
    chk("err_after_start", err, 0);
    chk("rdy_in_load", data_rdy, 1);
    for (int g = 0; g < garbage; g++) begin
      data = DW'($urandom);
      data_vld = 1'b1;
      step();
    end
    idx = 0;
    for (int y = 0; y < pic; y++)
      for (int x = 0; x < pic; x++)
        for (int b = 0; b < NB; b++) begin
          data       = img[y][x][b];
          data_vld   = 1'b1;
          data_sop   = (garbage > 0) && (idx == 0);
          data_hsync = ((x == pic - 1) && (b == NB - 1)) || (idx == bad_hs);
          step();
          idx++;
        end
    data_vld   = 1'b0;
    data_sop   = 1'b0;
    data_hsync = 1'b0;
  endtask

  task automatic wait_done(input int stall, input string nm);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 5000) begin
      if (stall != 0) begin
        opu_rdy = 1'b0;
        repeat (20) step();
        opu_rdy = 1'b1;
        step();
        opu_rdy = 1'b0;
        cyc += 21;
      end else begin
        step();
        cyc++;
      end
    end
    opu_rdy = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0 || busy) begin
      n_err++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b, required pending=0 busy=0",
               nm, exp_q.size(), busy);
    end
  endtask

  initial begin
    int base, cyc, seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_rdy", data_rdy, 0);
    chk("rst_opu_vld", opu_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_opu_x", opu_x, 0);
    rst_n = 1'b1;
    step();

    // 8x8, pad 1, stride 1, column-pair snake
    base = mon_cnt;
    run_frame(8, 1, 1, 1, 0, 0, -1);
    wait_done(0, "snake8");
    chk("snake8_beats", mon_cnt - base, 512);
    chk("snake8_w0_x", mon_x[base], -1);
    chk("snake8_w0_y", mon_y[base], -1);
    chk("snake8_w1_x", mon_x[base + NB], 0);
    chk("snake8_w1_y", mon_y[base + NB], -1);
    chk("snake8_w2_x", mon_x[base + 2 * NB], 0);
    chk("snake8_w2_y", mon_y[base + 2 * NB], 0);
    chk("snake8_w3_x", mon_x[base + 3 * NB], -1);
    chk("snake8_w3_y", mon_y[base + 3 * NB], 0);
    chk("snake8_w0_center_b5", mon_ctr[base + 5], 5);
    chk("snake8_eof_at_512", mon_eof[base + 511], 1);
    chk("snake8_no_early_eof", mon_eof[base + 510], 0);
    chk("snake8_err", err, 0);

    // 8x8, pad 0, stride 2, raster
    base = mon_cnt;
    run_frame(8, 0, 2, 0, 7, 0, -1);
    wait_done(0, "s2raster");
    chk("s2raster_beats", mon_cnt - base, 72);
    for (int w = 0; w < 9; w++) begin
      chk("s2raster_x", mon_x[base + w * NB], 2 * (w % 3));
      chk("s2raster_y", mon_y[base + w * NB], 2 * (w / 3));
    end

    // Back-pressure: 20 stall cycles per beat, odd Wout snake
    base = mon_cnt;
    run_frame(5, 1, 2, 1, 11, 0, -1);
    wait_done(1, "stall");
    chk("stall_beats", mon_cnt - base, 72);

    // Rejected configurations
    do_start(2, 0, 1, 0);
    chk("bad_small_err", err, 1);
    chk("bad_small_busy", busy, 0);
    chk("bad_small_rdy", data_rdy, 0);
    seen = 0;
    repeat (10) begin
      step();
      seen |= int'(opu_vld);
    end
    chk("bad_small_no_vld", seen, 0);
    do_start(17, 0, 1, 0);
    chk("bad_big_err", err, 1);
    do_start(8, 2, 1, 0);
    chk("bad_pad_err", err, 1);
    chk("bad_pad_busy", busy, 0);

    // SOP restart after 10 junk beats, plus a misplaced HSYNC
    base = mon_cnt;
    run_frame(6, 1, 1, 0, 23, 10, 5);
    chk("hsync_err_set", err, 1);
    wait_done(0, "sop");
    chk("sop_beats", mon_cnt - base, 288);
    chk("sop_err_sticky", err, 1);

    // Reset in the middle of emission, then a fresh frame
    base = mon_cnt;
    run_frame(4, 1, 1, 1, 40, 0, 3);
    cyc = 0;
    while (mon_cnt < base + 5 && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("pre_rst_beats_seen", (mon_cnt >= base + 5) ? 1 : 0, 1);
    chk("pre_rst_err", err, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", opu_vld, 0);
    chk("mid_rst_opu", |opu, 0);
    chk("mid_rst_bit", opu_bit, 0);
    chk("mid_rst_x", opu_x, 0);
    chk("mid_rst_y", opu_y, 0);
    chk("mid_rst_eof", opu_eof, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdy", data_rdy, 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    base = mon_cnt;
    run_frame(7, 1, 2, 1, 3, 0, -1);
    wait_done(0, "post_rst");
    chk("post_rst_beats", mon_cnt - base, 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/win_gen_kxk.md
WIN_GEN_KXK -- requirements
Module: win_gen_kxk

Interface
REQ-001 SHALL have parameter DW, default 128, lane width in bits of one bit-plane word.
REQ-002 SHALL have parameter NB, default 8, bit-planes per pixel.
REQ-003 SHALL have parameter K, default 3, kernel edge (odd, 1..7).
REQ-004 SHALL have parameter MAX_PIC, default 16, largest supported picture edge.
REQ-005 SHALL have parameter PW, default 8, width of size/coordinate fields.
REQ-006 SHALL have ports: SYS_CLK in 1 clock; SYS_RST in 1 async active-low reset; START in 1 frame-start pulse; PIC_SIZE in PW picture edge; PADDING in 2 zero-pad rows/cols per side; STRIDE in 1 (0 = stride 1, 1 = stride 2); MODE in 1 (0 raster, 1 column-pair snake).
REQ-007 SHALL have ports: DATA in DW plane word; DATA_VLD in 1; DATA_RDY out 1; DATA_SOP in 1 resets write pointer; DATA_HSYNC in 1 row-end marker.
REQ-008 SHALL have ports: OPU out K*K*DW window bit-plane; OPU_VLD out 1; OPU_RDY in 1; OPU_BIT out clog2(NB) plane index; OPU_X, OPU_Y out PW top-left coordinate (two's complement); OPU_EOF out 1; BUSY out 1; ERR out 1.

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> EMIT -> IDLE; BUSY = 1 outside IDLE.
REQ-010 SHALL, in IDLE on START=1, sample PIC_SIZE, PADDING, STRIDE, MODE; START outside IDLE ignored.
REQ-011 SHALL reject config (stay IDLE, ERR=1 sticky until next START) if PIC_SIZE=0, PIC_SIZE>MAX_PIC, PADDING>(K-1)/2, or PIC_SIZE+2*PADDING<K.
REQ-012 SHALL hold DATA_RDY=1 only in LOAD; beat = DATA_VLD&DATA_RDY.
REQ-013 SHALL accept input pixel-major, raster order, NB planes per pixel LSB-first; PIC_SIZE^2*NB beats total; after last beat enter EMIT next cycle.
REQ-014 SHALL reset write pointer to pixel 0 plane 0 on DATA_SOP=1 in LOAD (a beat in that same cycle is written to pixel 0 plane 0).
REQ-015 SHALL set ERR if DATA_HSYNC=1 on a beat other than last plane of a row's last pixel; loading continues.
REQ-016 SHALL store frame in internal register array (MAX_PIC^2*NB*DW bits, not reset).
REQ-017 SHALL compute Wout = floor((PIC_SIZE+2*PADDING-K)/S)+1, S = STRIDE?2:1; window (i,j) top-left = (i*S-PADDING, j*S-PADDING).
REQ-018 SHALL order windows MODE=0 row-major; MODE=1 column pairs (2p,2p+1) left to right, rows top to bottom within pair, even rows left->right, odd rows right->left; odd Wout leaves last pair single-column.
REQ-019 SHALL emit NB beats per window, OPU_BIT 0..NB-1, then next window.
REQ-020 SHALL pack OPU element (r,c) at bits [(K*K-1-(r*K+c))*DW +: DW], i.e. top-left in MSBs; element = stored plane OPU_BIT of that pixel, zero if pixel outside picture.
REQ-021 SHALL assert OPU_VLD one cycle after entering EMIT; OPU, OPU_BIT, OPU_X, OPU_Y, OPU_EOF registered and stable while OPU_VLD&!OPU_RDY.
REQ-022 SHALL present next beat the cycle after OPU_VLD&OPU_RDY (zero-bubble throughput of 1 beat/cycle with OPU_RDY=1).
REQ-023 SHALL assert OPU_EOF with last beat of last window; after its acceptance OPU_VLD=0 and FSM returns IDLE next cycle.

Reset
REQ-024 SHALL on SYS_RST=0, at any time including mid-LOAD/EMIT, immediately force IDLE, DATA_RDY=0, OPU_VLD=0, OPU=0, OPU_BIT=0, OPU_X=0, OPU_Y=0, OPU_EOF=0, BUSY=0, ERR=0, pointers 0.

Verification
REQ-025 SHALL cover: PIC=8,K=3,PAD=1,S=1,MODE=1, pixel(x,y)=y+8x broadcast per plane -> 512 beats; window 0 at (-1,-1), window 1 at (0,-1), window 2 at (0,0), window 3 at (-1,0); center element of window 0 = pixel(0,0); EOF on beat 512.
REQ-026 SHALL cover: PIC=8,PAD=0,S=2,MODE=0 -> Wout=3, 72 beats, top-lefts (0,0),(2,0),(4,0),(0,2)...(4,4).
REQ-027 SHALL cover: OPU_RDY held low 20 cycles per beat -> OPU/OPU_BIT/OPU_X/OPU_Y unchanged across stall, no beat lost or duplicated.
REQ-028 SHALL cover: PIC=2,PAD=0,K=3 START -> ERR=1, BUSY=0, DATA_RDY=0, no OPU_VLD; next valid START clears ERR.
REQ-029 SHALL cover: SYS_RST low mid-EMIT -> all outputs at reset values same cycle; new START reloads and streams correctly.
REQ-030 SHALL cover: DATA_SOP after 10 beats -> rewrite from pixel 0; misplaced DATA_HSYNC -> ERR=1, emission still completes.
